// File: rtl/led_display_package.sv
// Shared types for the HUB75 LED panel path: the pixel row layout, the row driver
// state encoding and the bit positions of the serial RGB lanes.
package led_display_package;

  localparam int PXL_COLS = 64;

  localparam int RGB_RED   = 0;
  localparam int RGB_GREEN = 1;
  localparam int RGB_BLUE  = 2;

  // Red occupies the most significant slice of a flattened row vector.
  typedef struct packed {
    logic [PXL_COLS-1:0] red;
    logic [PXL_COLS-1:0] green;
    logic [PXL_COLS-1:0] blue;
  } pxl_col_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH
  } hub75_state_t;

  // Counter width for a count limit, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/hub75_row_driver_bclk_gen.sv
// Panel shift clock generator: after a start strobe it runs NUM_COLS bclk periods of
// CLK_DIV low cycles then CLK_DIV high cycles, and strobes done as the last one falls.
module hub75_bclk_gen
  import led_display_package::*;
#(
  parameter  int CLK_DIV  = 2,
  parameter  int NUM_COLS = 64,
  localparam int CW       = cnt_w(NUM_COLS)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          start,
  output logic          bclk,
  output logic          rise,
  output logic          fall,
  output logic          done,
  output logic [CW-1:0] bit_cnt
);

  localparam int DW = cnt_w(CLK_DIV);

  logic          active;
  logic [DW-1:0] div_cnt;
  logic          phase_end;

  // Strobes announce what bclk does at the coming edge; fall excludes the final
  // period so the consumer loads a new bit only when one remains.
  assign phase_end = active && (div_cnt == DW'(CLK_DIV - 1));
  assign rise      = phase_end && !bclk;
  assign fall      = phase_end && bclk && (bit_cnt != CW'(NUM_COLS - 1));
  assign done      = phase_end && bclk && (bit_cnt == CW'(NUM_COLS - 1));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here sees pre-edge values.
    if (!n_reset) begin
      active  <= 1'b0;
      bclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      active  <= 1'b1;
      bclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= '0;
        bclk    <= !bclk;
        if (fall) bit_cnt <= bit_cnt + 1'b1;
        if (done) active  <= 1'b0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hub75_row_driver.sv
// HUB75 row driver: accepts one row-pair per handshake, shifts it out MSB column first,
// then blanks, latches and advances the scan address. Optional HUB75_TEST_PATTERN_EN
// adds test_en, which substitutes a column-index colour pattern for the upstream data.
module hub75_row_driver
  import led_display_package::*;
#(
  parameter  int NUM_COLS     = 64,
  parameter  int NUM_ROWS     = 32,
  parameter  int CLK_DIV      = 2,
  parameter  int BLANK_CYCLES = 4,
  parameter  int LATCH_CYCLES = 2,
  localparam int AW           = cnt_w(NUM_ROWS / 2),
  localparam int CW           = cnt_w(NUM_COLS)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [3*NUM_COLS-1:0] row_top,
  input  logic [3*NUM_COLS-1:0] row_bot,
`ifdef HUB75_TEST_PATTERN_EN
  input  logic                  test_en,
`endif
  output logic [AW-1:0]         row_req_addr,
  output logic                  bclk,
  output logic [2:0]            rgb_top,
  output logic [2:0]            rgb_bot,
  output logic [AW-1:0]         addr,
  output logic                  oe,
  output logic                  le,
  output logic                  frame_done
);

  localparam int BW = cnt_w(BLANK_CYCLES);
  localparam int LW = cnt_w(LATCH_CYCLES);

  hub75_state_t          state;
  logic [3*NUM_COLS-1:0] sr_top, sr_bot;
  logic [3*NUM_COLS-1:0] cap_top, cap_bot;
  logic                  first_latch;
  logic [BW-1:0]         blank_cnt;
  logic [LW-1:0]         latch_cnt;
  logic                  accept;
  logic                  bclk_rise, bclk_fall, shift_done;
  logic [CW-1:0]         bit_cnt, next_col;

  function automatic logic [2:0] pixel(input logic [3*NUM_COLS-1:0] row,
                                       input logic [CW-1:0] col);
    logic [2:0] p;
    p[RGB_RED]   = row[2*NUM_COLS + col];
    p[RGB_GREEN] = row[NUM_COLS + col];
    p[RGB_BLUE]  = row[col];
    return p;
  endfunction

`ifdef HUB75_TEST_PATTERN_EN
  logic [3*NUM_COLS-1:0] pat_top;

  always_comb begin
    // NOTE: default first so no path through the loop can leave a bit unassigned.
    pat_top = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      pat_top[2*NUM_COLS + c] = c[0];
      pat_top[NUM_COLS + c]   = c[1];
      pat_top[c]              = c[2];
    end
  end

  assign accept  = row_ready && (row_valid || test_en);
  assign cap_top = test_en ? pat_top : row_top;
  assign cap_bot = test_en ? ~pat_top : row_bot;
`else
  assign accept  = row_ready && row_valid;
  assign cap_top = row_top;
  assign cap_bot = row_bot;
`endif

  // Column presented after the fall that ends bit bit_cnt.
  assign next_col = CW'(NUM_COLS - 2) - bit_cnt;

  hub75_bclk_gen #(
    .CLK_DIV  (CLK_DIV),
    .NUM_COLS (NUM_COLS)
  ) u_bclk_gen (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (accept),
    .bclk    (bclk),
    .rise    (bclk_rise),
    .fall    (bclk_fall),
    .done    (shift_done),
    .bit_cnt (bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state        <= IDLE;
      row_ready    <= 1'b0;
      row_req_addr <= '0;
      addr         <= '0;
      rgb_top      <= '0;
      rgb_bot      <= '0;
      oe           <= 1'b1;
      le           <= 1'b0;
      frame_done   <= 1'b0;
      first_latch  <= 1'b0;
      // NOTE: row registers are cleared too, so a reset mid-row leaves no stale pixels.
      sr_top       <= '0;
      sr_bot       <= '0;
      blank_cnt    <= '0;
      latch_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          row_ready <= 1'b1;
          oe        <= !first_latch;
          if (accept) begin
            sr_top    <= cap_top;
            sr_bot    <= cap_bot;
            rgb_top   <= pixel(cap_top, CW'(NUM_COLS - 1));
            rgb_bot   <= pixel(cap_bot, CW'(NUM_COLS - 1));
            row_ready <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bclk_fall) begin
            rgb_top <= pixel(sr_top, next_col);
            rgb_bot <= pixel(sr_bot, next_col);
          end
          if (shift_done) begin
            rgb_top   <= '0;
            rgb_bot   <= '0;
            oe        <= 1'b1;
            blank_cnt <= '0;
            state     <= BLANK;
          end
        end
        BLANK: begin
          if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            le        <= 1'b1;
            addr      <= row_req_addr;
            latch_cnt <= '0;
            state     <= LATCH;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (latch_cnt == LW'(LATCH_CYCLES - 1)) begin
            le          <= 1'b0;
            oe          <= 1'b0;
            first_latch <= 1'b1;
            row_ready   <= 1'b1;
            state       <= IDLE;
            if (row_req_addr == AW'(NUM_ROWS / 2 - 1)) begin
              row_req_addr <= '0;
              frame_done   <= 1'b1;
            end else begin
              row_req_addr <= row_req_addr + 1'b1;
            end
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Panel samples data on bclk rising, so the lanes must hold across that edge.
  a_rgb_stable_on_rise: assert property (@(posedge clk) disable iff (!n_reset)
    bclk_rise |=> ($stable(rgb_top) && $stable(rgb_bot)));

endmodule
